mem_bus_arbiter: RTL and testbench

//  Shares the single NPC memory port between the IFU (instruction fetch) and the LSU (load/store).

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/arb_watchdog.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IFU/LSU memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_WAIT
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IFU,
      OWN_LSU
   } arb_owner_e;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags
// the terminal cycle of the allowed window.
module arb_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + CW'(1);
   end

   assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between IFU and LSU, one transaction
// in flight, response routed to its issuer, watchdog abort -> bus_err.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                bus_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    state;
   arb_state_e    state_nx;
   arb_owner_e    owner;
   logic [SW-1:0] streak;
   logic          starved;
   logic          grant_ifu;
   logic          grant_lsu;
   logic          accept;
   logic          done;
   logic          abort;
   logic          expired;

   assign starved = (streak == SW'(STARVE_LIMIT));

   // LSU has priority until IFU has waited out STARVE_LIMIT grants
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (state == ARB_IDLE && !rst) begin
         if (lsu_req_valid && !(ifu_req_valid && starved))
            grant_lsu = 1'b1;
         else if (ifu_req_valid)
            grant_ifu = 1'b1;
      end
   end

   assign ifu_req_ready = grant_ifu;
   assign lsu_req_ready = grant_lsu;
   assign accept        = grant_ifu | grant_lsu;
   assign mem_req_valid = (state == ARB_REQ);
   assign done          = (state == ARB_WAIT) && mem_resp_valid;
   assign abort         = expired && !done;

   arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (state != ARB_IDLE),
      .expired(expired)
   );

   always_comb begin
      state_nx       = state;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      bus_err        = 1'b0;
      unique case (state)
         ARB_IDLE: if (accept) state_nx = ARB_REQ;
         ARB_REQ: begin
            if (expired)
               state_nx = ARB_IDLE;
            else if (mem_req_ready)
               state_nx = ARB_WAIT;
         end
         ARB_WAIT: if (done || expired) state_nx = ARB_IDLE;
         default: state_nx = ARB_IDLE;
      endcase
      if (done || abort) begin
         bus_err = abort;
         if (owner == OWN_IFU) begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = done ? mem_rdata : '0;
         end else if (owner == OWN_LSU) begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = done ? mem_rdata : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ARB_IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_NONE;
         streak    <= '0;
         mem_addr  <= '0;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if (accept) begin
         owner     <= grant_lsu ? OWN_LSU : OWN_IFU;
         mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
         mem_wen   <= grant_lsu & lsu_wen;
         mem_wdata <= grant_lsu ? lsu_wdata : '0;
         mem_wmask <= grant_lsu ? lsu_wmask : '0;
         if (grant_lsu && ifu_req_valid)
            streak <= starved ? streak : streak + SW'(1);
         else
            streak <= '0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter against a
// transaction-level reference model.
module tb_mem_bus_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MW  = DW / 8;
   localparam int LIM = 4;
   localparam int TO  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ifu_req_valid = 1'b0;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_addr = '0;
   logic          ifu_resp_valid;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid = 1'b0;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_addr = '0;
   logic          lsu_wen = 1'b0;
   logic [DW-1:0] lsu_wdata = '0;
   logic [MW-1:0] lsu_wmask = '0;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_rdata;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_resp_valid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          bus_err;

   mem_bus_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
      .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
      .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Transaction-level model: one record of the in-flight transfer
   bit            m_busy, m_taken, m_lsu, m_wen;
   int            m_age, m_streak;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [MW-1:0] m_wmask;
   bit            e_lrdy, e_irdy, e_done, e_abort;
   bit            log_on = 0;
   byte           grant_q[$];

   task automatic m_reset();
      m_busy = 0; m_taken = 0; m_lsu = 0; m_wen = 0;
      m_age = 0; m_streak = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic step();
      e_lrdy  = !m_busy && lsu_req_valid && !(ifu_req_valid && m_streak == LIM);
      e_irdy  = !m_busy && ifu_req_valid && !e_lrdy;
      e_done  = m_busy && m_taken && mem_resp_valid;
      e_abort = m_busy && !e_done && m_age == TO;
      chk("ifu_rdy", ifu_req_ready, e_irdy);
      chk("lsu_rdy", lsu_req_ready, e_lrdy);
      chk("mreq", mem_req_valid, m_busy && !m_taken);
      chk("ifu_resp", ifu_resp_valid, (e_done || e_abort) && !m_lsu);
      chk("lsu_resp", lsu_resp_valid, (e_done || e_abort) && m_lsu);
      chk("ifu_rdata", ifu_rdata, (e_done && !m_lsu) ? mem_rdata : '0);
      chk("lsu_rdata", lsu_rdata, (e_done && m_lsu) ? mem_rdata : '0);
      chk("bus_err", bus_err, e_abort);
      chk("addr", mem_addr, m_addr);
      chk("wen", mem_wen, m_wen);
      chk("wmask", mem_wmask, m_wmask);
      if (m_wen) chk("wdata", mem_wdata, m_wdata);
      if (log_on && ifu_req_ready && ifu_req_valid) grant_q.push_back("I");
      if (log_on && lsu_req_ready && lsu_req_valid) grant_q.push_back("L");
      if (e_lrdy) begin
         m_busy = 1; m_taken = 0; m_age = 1; m_lsu = 1;
         m_addr = lsu_addr; m_wen = lsu_wen;
         m_wdata = lsu_wdata; m_wmask = lsu_wmask;
         m_streak = ifu_req_valid ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
      end else if (e_irdy) begin
         m_busy = 1; m_taken = 0; m_age = 1; m_lsu = 0;
         m_addr = ifu_addr; m_wen = 0; m_wmask = '0;
         m_streak = 0;
      end else if (m_busy) begin
         if (e_done || e_abort)
            m_busy = 0;
         else begin
            if (!m_taken && mem_req_ready) m_taken = 1;
            m_age++;
         end
      end
      @(negedge clk);
   endtask

   task automatic tick();
      settle();
      step();
   endtask

   task automatic drain();
      ifu_req_valid = 0; lsu_req_valid = 0;
      mem_req_ready = 1; mem_resp_valid = 1;
      for (int i = 0; i < 40 && m_busy; i++) tick();
      chk("drain_idle", m_busy, 0);
      mem_req_ready = 0; mem_resp_valid = 0;
   endtask

   task automatic lsu_issue(input logic [AW-1:0] a, input logic w);
      lsu_req_valid = 1; lsu_addr = a; lsu_wen = w;
      lsu_wdata = $urandom; lsu_wmask = 4'hF;
      tick();
      lsu_req_valid = 0;
   endtask

   initial begin
      string exp_s;
      m_reset();
      @(negedge clk);
      settle();
      chk("rst_state", {ifu_req_ready, lsu_req_ready, mem_req_valid,
                        ifu_resp_valid, lsu_resp_valid, bus_err, mem_wen}, '0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_wdata", mem_wdata, '0);
      rst = 0;
      @(negedge clk);

      // IFU fetch, fastest turnaround
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
      tick();
      ifu_req_valid = 0;
      settle();
      chk("t1_mreq", mem_req_valid, 1);
      step();
      mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
      settle();
      chk("t1_resp", ifu_resp_valid, 1);
      chk("t1_rdata", ifu_rdata, 32'h0000_0413);
      chk("t1_lsu", lsu_resp_valid, 0);
      step();
      mem_resp_valid = 0;

      // Simultaneous requests: LSU first, IFU next idle cycle
      ifu_req_valid = 1; lsu_req_valid = 1; lsu_addr = 32'h8000_0040;
      settle();
      chk("t2_lrdy", lsu_req_ready, 1);
      chk("t2_irdy", ifu_req_ready, 0);
      step();
      lsu_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1;
      tick();
      tick();
      settle();
      chk("t2_ifu_next", ifu_req_ready, 1);
      step();
      drain();

      // Starvation: grant order with both requesters always valid
      ifu_req_valid = 1; lsu_req_valid = 1;
      mem_req_ready = 1; mem_resp_valid = 1;
      log_on = 1;
      for (int i = 0; i < 18; i++) tick();
      log_on = 0;
      exp_s = "LLLLIL";
      chk("grant_cnt", grant_q.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("grant%0d", i), grant_q[i], exp_s[i]);
      drain();

      // Store held in REQ for 3 cycles
      lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'h1234_ABCD; lsu_wmask = 4'b0011;
      tick();
      lsu_req_valid = 0; lsu_addr = 32'hDEAD_0000; lsu_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_wen", mem_wen, 1);
         chk("t4_addr", mem_addr, 32'h8000_1000);
         chk("t4_wdata", mem_wdata, 32'h1234_ABCD);
         step();
      end
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_resp_valid = 1;
      settle();
      chk("t4_resp", lsu_resp_valid, 1);
      step();
      mem_resp_valid = 0;

      // Timeout in WAIT, then response on the expiring cycle
      for (int v = 0; v < 2; v++) begin
         lsu_issue(32'h8000_2000, 0);
         mem_req_ready = 1;
         tick();
         mem_req_ready = 0;
         for (int k = 2; k < TO; k++) tick();
         mem_resp_valid = (v == 1); mem_rdata = 32'h0000_CAFE;
         settle();
         chk("t5_resp", lsu_resp_valid, 1);
         chk("t5_err", bus_err, v == 0);
         chk("t5_rdata", lsu_rdata, (v == 1) ? 32'h0000_CAFE : 32'h0);
         step();
         mem_resp_valid = 0;
         settle();
         chk("t5_err_gone", bus_err, 0);
         step();
      end

      // Timeout with the request never accepted
      lsu_issue(32'h8000_3000, 1);
      for (int k = 1; k < TO; k++) tick();
      settle();
      chk("t5_req_err", bus_err, 1);
      step();

      // Reset during WAIT abandons the transaction
      lsu_issue(32'h8000_4000, 0);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      settle();
      rst = 1;
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      chk("t6_ctl", {ifu_req_ready, lsu_req_ready, mem_req_valid,
                     ifu_resp_valid, lsu_resp_valid, bus_err, mem_wen}, '0);
      chk("t6_addr", mem_addr, '0);
      chk("t6_mask", mem_wmask, '0);
      m_reset();
      ifu_req_valid = 0; lsu_req_valid = 0;
      @(negedge clk);
      rst = 0;
      mem_resp_valid = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t6_no_resp", lsu_resp_valid, 0);
         step();
      end
      mem_resp_valid = 0;

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         int ph;
         ph = (i / 150) % 3;
         ifu_req_valid  = $urandom_range(0, 1);
         lsu_req_valid  = $urandom_range(0, 1);
         ifu_addr       = $urandom;
         lsu_addr       = $urandom;
         lsu_wen        = $urandom_range(0, 1);
         lsu_wdata      = $urandom;
         lsu_wmask      = MW'($urandom);
         mem_req_ready  = (ph == 1) ? ($urandom_range(0, 7) == 0)
                                    : ($urandom_range(0, 1) == 1);
         mem_resp_valid = (ph == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
         mem_rdata      = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
